riego_scheduler: RTL and testbench

//  Irrigation scheduler fed by the serial field decoder (humedad/hora/tipoPlanta/listo).

---
 rtl/riego_pkg.sv | 55 +++++
 rtl/riego_sync_flanco.sv | 27 ++
 rtl/riego_scheduler.sv | 141 ++++++++++++++
 tb/tb_riego_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riego_pkg.sv
// Shared types and helpers for the irrigation scheduler: FSM encoding,
// per-plant humidity thresholds, watering hour windows and BCD validation/conversion.
package riego_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVAL   = 3'd1,
        RIEGO  = 3'd2,
        ESPERA = 3'd3,
        FALLA  = 3'd4
    } estado_t;

    // Half-open hour windows [INI, FIN) in which watering is allowed
    localparam logic [4:0] VENT_A_INI = 5'd6;
    localparam logic [4:0] VENT_A_FIN = 5'd10;
    localparam logic [4:0] VENT_B_INI = 5'd18;
    localparam logic [4:0] VENT_B_FIN = 5'd21;

    function automatic logic [6:0] umbral(input logic [3:0] tipo);
        logic [6:0] thr;
        case (tipo)
            4'd0:    thr = 7'd20;
            4'd1:    thr = 7'd30;
            4'd2:    thr = 7'd45;
            4'd3:    thr = 7'd60;
            4'd4:    thr = 7'd55;
            default: thr = 7'd40;
        endcase
        return thr;
    endfunction

    function automatic logic en_ventana(input logic [4:0] hh);
        return ((hh >= VENT_A_INI) && (hh < VENT_A_FIN)) ||
               ((hh >= VENT_B_INI) && (hh < VENT_B_FIN));
    endfunction

    // Every nibble of {humedad, hora} must be a legal BCD digit
    function automatic logic bcd_ok(input logic [27:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [9:0] bcd3_bin(input logic [11:0] b);
        return {6'd0, b[11:8]} * 10'd100 + {6'd0, b[7:4]} * 10'd10 + {6'd0, b[3:0]};
    endfunction

    function automatic logic [6:0] bcd2_bin(input logic [7:0] b);
        return {3'd0, b[7:4]} * 7'd10 + {3'd0, b[3:0]};
    endfunction

endpackage

// File: rtl/riego_sync_flanco.sv
// Purpose: 2-FF synchronizer for an asynchronous level plus rising-edge pulse.
// Latency: pulso_o asserts for one clk, 2 clk after d_i rises.
// Backpressure: none; a held-high level yields a single pulse.
module sync_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulso_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulso_o = s2_q & ~s3_q;

endmodule

// File: rtl/riego_scheduler.sv
// Purpose: validates decoder frames and runs timed pump/soak cycles with dry-frame lockout.
// Latency: listo rise -> bomba rise in 5 clk (sync 2, capture 1, EVAL 1, RIEGO 1).
// Backpressure: none; frames arriving while busy are held in one pending slot, last wins.
module riego_scheduler
    import riego_pkg::*;
#(
    parameter int PRESC      = 50000,
    parameter int T_RIEGO    = 10,
    parameter int T_ESPERA   = 30,
    parameter int MAX_CICLOS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        listo,
    input  logic [11:0] humedad,
    input  logic [15:0] hora,
    input  logic [3:0]  tipoPlanta,
    output logic        bomba,
    output logic        ocupado,
    output logic        error_dato,
    output logic        falla,
    output logic [2:0]  ciclos
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    estado_t     state_q, state_d;
    logic        pend_q, pend_d;
    logic [6:0]  hum_q;
    logic [4:0]  hh_q;
    logic [3:0]  tipo_q;
    logic [2:0]  ciclos_q, ciclos_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0] tick_q, tick_d;
    logic        err_q;

    logic        frame_evt;
    logic [9:0]  hum_raw;
    logic [6:0]  hh_raw, mm_raw;
    logic        valido, captura, tick;

    sync_flanco u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (listo),
        .pulso_o (frame_evt)
    );

    assign hum_raw = bcd3_bin(humedad);
    assign hh_raw  = bcd2_bin(hora[15:8]);
    assign mm_raw  = bcd2_bin(hora[7:0]);
    assign valido  = bcd_ok({humedad, hora}) && (hum_raw <= 10'd100) &&
                     (hh_raw <= 7'd23) && (mm_raw <= 7'd59);
    assign captura = frame_evt && valido;
    assign tick    = (pre_q == PW'(PRESC - 1));

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ciclos_d = ciclos_q;
        pre_d    = pre_q;
        tick_d   = tick_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = EVAL;
                    pend_d  = 1'b0;
                end
            end
            EVAL: begin
                if (hum_q >= umbral(tipo_q)) begin
                    ciclos_d = 3'd0;
                    state_d  = IDLE;
                end else if (!en_ventana(hh_q)) begin
                    state_d = IDLE;
                end else if (ciclos_q == 3'(MAX_CICLOS)) begin
                    state_d = FALLA;
                end else begin
                    ciclos_d = ciclos_q + 3'd1;
                    state_d  = RIEGO;
                    pre_d    = '0;
                    tick_d   = '0;
                end
            end
            RIEGO, ESPERA: begin
                // Timers restart on every phase entry so each phase is exactly N*PRESC clk
                if (tick) begin
                    pre_d = '0;
                    if (state_q == RIEGO && tick_q == 16'(T_RIEGO - 1)) begin
                        state_d = ESPERA;
                        tick_d  = '0;
                    end else if (state_q == ESPERA && tick_q == 16'(T_ESPERA - 1)) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            FALLA: state_d = FALLA;
            default: state_d = IDLE;
        endcase
        // A new frame outranks the IDLE clear so it is never lost; lockout ignores frames
        if (captura && state_q != FALLA) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            hum_q    <= '0;
            hh_q     <= '0;
            tipo_q   <= '0;
            ciclos_q <= '0;
            pre_q    <= '0;
            tick_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ciclos_q <= ciclos_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            err_q    <= frame_evt && !valido;
            if (captura) begin
                hum_q  <= hum_raw[6:0];
                hh_q   <= hh_raw[4:0];
                tipo_q <= tipoPlanta;
            end
        end
    end

    assign bomba      = (state_q == RIEGO);
    assign ocupado    = (state_q == RIEGO) || (state_q == ESPERA);
    assign falla      = (state_q == FALLA);
    assign error_dato = err_q;
    assign ciclos     = ciclos_q;

endmodule

// File: tb/tb_riego_scheduler.sv
// Directed bench for riego_scheduler: vector table of single frames plus
// hand-written sequences for reset, lockout, last-wins and held-listo cases.
module tb_riego_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        listo;
    logic [11:0] humedad;
    logic [15:0] hora;
    logic [3:0]  tipoPlanta;
    logic        bomba, ocupado, error_dato, falla;
    logic [2:0]  ciclos;

    int tests = 0;
    int fails = 0;
    int bomba_rises;
    logic bomba_prev;
    int lat, blen, olen, errs;

    riego_scheduler #(
        .PRESC(4), .T_RIEGO(3), .T_ESPERA(2), .MAX_CICLOS(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .listo      (listo),
        .humedad    (humedad),
        .hora       (hora),
        .tipoPlanta (tipoPlanta),
        .bomba      (bomba),
        .ocupado    (ocupado),
        .error_dato (error_dato),
        .falla      (falla),
        .ciclos     (ciclos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] hum;
        logic [15:0] hr;
        logic [3:0]  tipo;
        bit          pump;
        bit          err;
        int          cic;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bomba && !bomba_prev) bomba_rises++;
        bomba_prev = bomba;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        listo = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bomba_prev = 1'b0;
        bomba_rises = 0;
        tick();
    endtask

    // Presents one frame and watches a fixed window long enough for a full cycle
    task automatic run_frame(input logic [11:0] h, input logic [15:0] hr, input logic [3:0] t,
                             output int o_lat, output int o_blen, output int o_olen,
                             output int o_errs);
        o_lat = -1; o_blen = 0; o_olen = 0; o_errs = 0;
        humedad = h; hora = hr; tipoPlanta = t; listo = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) listo = 1'b0;
            if (bomba) begin
                o_blen++;
                if (o_lat < 0) o_lat = i;
            end
            if (ocupado) o_olen++;
            if (error_dato) o_errs++;
        end
    endtask

    initial begin
        vt[0]  = '{12'h025, 16'h0730, 4'd3,  1, 0, 1};
        vt[1]  = '{12'h070, 16'h0730, 4'd3,  0, 0, 0};
        vt[2]  = '{12'h025, 16'h0730, 4'd3,  1, 0, 1};
        vt[3]  = '{12'h025, 16'h1200, 4'd3,  0, 0, 1};
        vt[4]  = '{12'h0A5, 16'h0730, 4'd3,  0, 1, 1};
        vt[5]  = '{12'h025, 16'h2460, 4'd3,  0, 1, 1};
        vt[6]  = '{12'h019, 16'h1830, 4'd0,  1, 0, 2};
        vt[7]  = '{12'h100, 16'h0900, 4'd2,  0, 0, 0};
        vt[8]  = '{12'h101, 16'h0800, 4'd2,  0, 1, 0};
        vt[9]  = '{12'h044, 16'h2059, 4'd2,  1, 0, 1};
        vt[10] = '{12'h030, 16'h2100, 4'd7,  0, 0, 1};
        vt[11] = '{12'h054, 16'h0600, 4'd4,  1, 0, 2};
        vt[12] = '{12'h029, 16'h0559, 4'd1,  0, 0, 2};
        vt[13] = '{12'h040, 16'h0959, 4'd5,  0, 0, 0};
        vt[14] = '{12'h025, 16'h1960, 4'd3,  0, 1, 0};
        vt[15] = '{12'h025, 16'h0A00, 4'd3,  0, 1, 0};
        vt[16] = '{12'h0F0, 16'h0800, 4'd3,  0, 1, 0};
        vt[17] = '{12'h099, 16'h0800, 4'd15, 0, 0, 0};
        vt[18] = '{12'h019, 16'h2359, 4'd0,  0, 0, 0};
        vt[19] = '{12'h059, 16'h1959, 4'd3,  1, 0, 1};
        vt[20] = '{12'h010, 16'h1759, 4'd0,  0, 0, 1};
        vt[21] = '{12'h000, 16'h0700, 4'd0,  1, 0, 2};

        humedad = '0; hora = '0; tipoPlanta = '0; listo = 1'b0;
        rst_n = 1'b0;
        bomba_prev = 1'b0;
        bomba_rises = 0;
        #3;
        chk("reset_bomba",   int'(bomba), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_error",   int'(error_dato), 0);
        chk("reset_falla",   int'(falla), 0);
        chk("reset_ciclos",  int'(ciclos), 0);
        do_reset();

        for (int v = 0; v < 22; v++) begin
            run_frame(vt[v].hum, vt[v].hr, vt[v].tipo, lat, blen, olen, errs);
            chk($sformatf("v%0d_latency", v), lat,  vt[v].pump ? 5 : -1);
            chk($sformatf("v%0d_bomba_len", v), blen, vt[v].pump ? 12 : 0);
            chk($sformatf("v%0d_ocupado_len", v), olen, vt[v].pump ? 20 : 0);
            chk($sformatf("v%0d_error_pulses", v), errs, vt[v].err ? 1 : 0);
            chk($sformatf("v%0d_ciclos", v), int'(ciclos), vt[v].cic);
            chk($sformatf("v%0d_falla", v), int'(falla), 0);
        end

        // Asynchronous reset in the middle of a pump phase
        do_reset();
        humedad = 12'h025; hora = 16'h0730; tipoPlanta = 4'd3; listo = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 3) listo = 1'b0;
        end
        chk("midriego_bomba_before", int'(bomba), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midriego_bomba_rst",   int'(bomba), 0);
        chk("midriego_ocupado_rst", int'(ocupado), 0);
        chk("midriego_ciclos_rst",  int'(ciclos), 0);
        tick();
        rst_n = 1'b1;
        bomba_prev = 1'b0;
        bomba_rises = 0;
        for (int i = 0; i < 30; i++) tick();
        chk("midriego_no_pending", bomba_rises, 0);

        // Repeated dry frames lead to lockout
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            run_frame(12'h025, 16'h0730, 4'd3, lat, blen, olen, errs);
            chk($sformatf("lock_f%0d_latency", f), lat, 5);
            chk($sformatf("lock_f%0d_ciclos", f), int'(ciclos), f);
        end
        run_frame(12'h025, 16'h0730, 4'd3, lat, blen, olen, errs);
        chk("lock_f4_no_bomba", lat, -1);
        chk("lock_f4_falla",    int'(falla), 1);
        chk("lock_f4_ciclos",   int'(ciclos), 3);
        run_frame(12'h025, 16'h0800, 4'd0, lat, blen, olen, errs);
        chk("lock_f5_no_bomba", lat, -1);
        chk("lock_f5_falla",    int'(falla), 1);
        run_frame(12'h0A5, 16'h0730, 4'd3, lat, blen, olen, errs);
        chk("lock_bad_error",   errs, 1);
        chk("lock_bad_falla",   int'(falla), 1);

        // Two frames during RIEGO: the wet second one must win
        do_reset();
        humedad = 12'h025; hora = 16'h0730; tipoPlanta = 4'd3; listo = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 3) listo = 1'b0;
            if (i == 6) begin humedad = 12'h010; listo = 1'b1; end
            if (i == 8) listo = 1'b0;
            if (i == 10) begin humedad = 12'h080; listo = 1'b1; end
            if (i == 12) listo = 1'b0;
            if (i == 14) chk("lastwin_ciclos_mid", int'(ciclos), 1);
        end
        chk("lastwin_one_pump", bomba_rises, 1);
        chk("lastwin_ciclos",   int'(ciclos), 0);

        // listo held high yields a single event
        do_reset();
        humedad = 12'h025; hora = 16'h0730; tipoPlanta = 4'd3; listo = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        chk("held_one_pump", bomba_rises, 1);
        chk("held_ciclos",   int'(ciclos), 1);
        listo = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
